mem_port_arbiter: RTL

- Shares one single-ported instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (loads/stores driven by ctrl_mem_read/ctrl_mem_write).
- Sequences each RAM access as a request/ready transaction and returns the result with a one-cycle ack pulse.
- Generates per-stage stall signals for the pipeline.
- MEM has fixed priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported RAM between instruction fetch (IF) and the data
// stage (MEM). Each RAM access is a ce/ready transaction. Completion is
// signalled to the winning requester with a one-cycle ack. MEM has fixed
// priority; a starvation counter forces fetch to win after STARVE_MAX
// consecutive losses.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no RAM access in flight; arbitrate on the next edge
// S_BUS_IF  | fetch access in flight; ram_* held until ram_ready_i
// S_BUS_MEM | load/store access in flight; ram_* held until ram_ready_i
// S_DONE    | ack cycle; no arbitration so the requester can drop its request
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              if_ack_o,

    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,

    output logic              stall_if_o,
    output logic              stall_mem_o,

    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUS_IF  = 2'd1,
        S_BUS_MEM = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [3:0]        r_starve;
    logic              r_ram_ce;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_if_inst;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_ack;
    logic              r_mem_ack;

    logic [3:0]        w_starve_nxt;
    logic              w_ram_ce_nxt;
    logic              w_ram_we_nxt;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic [DATA_W-1:0] w_ram_wdata_nxt;
    logic [DATA_W-1:0] w_if_inst_nxt;
    logic [DATA_W-1:0] w_mem_rdata_nxt;
    logic              w_if_ack_nxt;
    logic              w_mem_ack_nxt;

    logic              w_if_pend;
    logic              w_mem_pend;
    logic              w_grant_mem;
    logic              w_grant_if;

    assign w_if_pend  = if_req_i;
    assign w_mem_pend = mem_read_i | mem_write_i;

    // MEM wins unless fetch has lost STARVE_MAX times in a row.
    assign w_grant_mem = w_mem_pend && ((r_starve < LP_STARVE_MAX) || !w_if_pend);
    assign w_grant_if  = w_if_pend  && (!w_mem_pend || (r_starve == LP_STARVE_MAX));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: arbitrate in IDLE, wait for ready on the bus, one ack cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_mem) begin
                    w_state_nxt = S_BUS_MEM;
                end else if (w_grant_if) begin
                    w_state_nxt = S_BUS_IF;
                end
            end
            S_BUS_IF, S_BUS_MEM: begin
                if (ram_ready_i) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: next values of the registered RAM bus, result and ack registers.
    always_comb begin
        w_starve_nxt    = r_starve;
        w_ram_ce_nxt    = r_ram_ce;
        w_ram_we_nxt    = r_ram_we;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_if_inst_nxt   = r_if_inst;
        w_mem_rdata_nxt = r_mem_rdata;
        w_if_ack_nxt    = 1'b0;
        w_mem_ack_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_mem) begin
                    w_ram_ce_nxt    = 1'b1;
                    // read and write together is treated as a store
                    w_ram_we_nxt    = mem_write_i;
                    w_ram_addr_nxt  = mem_addr_i;
                    w_ram_wdata_nxt = mem_wdata_i;
                    if (w_if_pend && (r_starve < LP_STARVE_MAX)) begin
                        w_starve_nxt = r_starve + 4'd1;
                    end
                end else if (w_grant_if) begin
                    w_ram_ce_nxt   = 1'b1;
                    w_ram_we_nxt   = 1'b0;
                    w_ram_addr_nxt = if_addr_i;
                    w_starve_nxt   = 4'd0;
                end
            end
            S_BUS_IF: begin
                if (ram_ready_i) begin
                    w_ram_ce_nxt  = 1'b0;
                    w_ram_we_nxt  = 1'b0;
                    w_if_inst_nxt = ram_rdata_i;
                    w_if_ack_nxt  = 1'b1;
                end
            end
            S_BUS_MEM: begin
                if (ram_ready_i) begin
                    w_ram_ce_nxt  = 1'b0;
                    w_ram_we_nxt  = 1'b0;
                    // stores leave the last load result untouched
                    if (!r_ram_we) begin
                        w_mem_rdata_nxt = ram_rdata_i;
                    end
                    w_mem_ack_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset aborts any in-flight access without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve    <= 4'd0;
            r_ram_ce    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_inst   <= '0;
            r_mem_rdata <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
        end else begin
            r_starve    <= w_starve_nxt;
            r_ram_ce    <= w_ram_ce_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_if_inst   <= w_if_inst_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_mem_ack   <= w_mem_ack_nxt;
        end
    end

    assign ram_ce_o    = r_ram_ce;
    assign ram_we_o    = r_ram_we;
    assign ram_addr_o  = r_ram_addr;
    assign ram_wdata_o = r_ram_wdata;
    assign if_inst_o   = r_if_inst;
    assign mem_rdata_o = r_mem_rdata;
    assign if_ack_o    = r_if_ack;
    assign mem_ack_o   = r_mem_ack;

    assign stall_if_o  = if_req_i & ~r_if_ack;
    assign stall_mem_o = w_mem_pend & ~r_mem_ack;

endmodule
